// File: rtl/code_patch_cfg_ctrl.sv
// Purpose: Wishbone config slave holding shadow pattern registers; a commit copies them to the active outputs atomically.
// Latency: config ack/err one cycle after the request is sampled; an idle-bus commit reaches the outputs two edges after acceptance.
// Backpressure: one access per two cycles; shadow/commit writes get err while a commit is pending; the commit waits for mon_cyc_i idle, up to TIMEOUT cycles.
module code_patch_cfg_ctrl #(
  parameter int ADDR_WIDTH          = 16,
  parameter int DATA_WIDTH          = 16,
  parameter int NUM_REGS            = 2,
  parameter int SUB_REGS_DATA_WIDTH = 16,
  parameter int TIMEOUT             = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DATA_WIDTH-1:0]          cfg_dat_i,
  input  logic [7:0]                     cfg_adr_i,
  input  logic                           cfg_cyc_i,
  input  logic                           cfg_stb_i,
  input  logic                           cfg_we_i,
  output logic [DATA_WIDTH-1:0]          cfg_dat_o,
  output logic                           cfg_ack_o,
  output logic                           cfg_err_o,
  input  logic                           mon_cyc_i,
  output logic                           cfg_pat_gen_o,
  output logic                           cfg_addr_or_data_o,
  output logic [ADDR_WIDTH-1:0]          ctl_pat_addr_o [NUM_REGS],
  output logic [SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_o [NUM_REGS],
  output logic [NUM_REGS-1:0]            ctl_pat_pen_o,
  output logic [NUM_REGS-1:0]            ctl_pat_nopg_o,
  output logic                           commit_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t                         state;
  logic [15:0]                    wait_cnt;
  logic                           timeout_flag;
  logic                           sh_pat_gen;
  logic                           sh_addr_or_data;
  logic [NUM_REGS-1:0]            sh_pen;
  logic [NUM_REGS-1:0]            sh_nopg;
  logic [ADDR_WIDTH-1:0]          sh_addr [NUM_REGS];
  logic [SUB_REGS_DATA_WIDTH-1:0] sh_data [NUM_REGS];

  logic                  pending;
  logic                  req;
  logic                  mapped;
  logic                  err_cond;
  logic                  wr_en;
  logic                  wr_ctrl;
  logic [DATA_WIDTH-1:0] rd_dat;

  assign pending = (state != ST_IDLE);
  // A response in flight blocks re-sampling, so a held strobe yields one ack every other cycle
  assign req     = cfg_cyc_i & cfg_stb_i & ~cfg_ack_o & ~cfg_err_o;

  // Address decode and zero-extended read-data mux
  always_comb begin
    mapped = 1'b0;
    rd_dat = '0;
    case (cfg_adr_i)
      8'h00: begin mapped = 1'b1; rd_dat[1:0] = {sh_addr_or_data, sh_pat_gen}; end
      8'h01: begin mapped = 1'b1; rd_dat[1:0] = {timeout_flag, pending}; end
      8'h02: begin mapped = 1'b1; rd_dat[NUM_REGS-1:0] = sh_pen; end
      8'h03: begin mapped = 1'b1; rd_dat[NUM_REGS-1:0] = sh_nopg; end
      default: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (cfg_adr_i == {4'h1, 4'(i)}) begin
            mapped = 1'b1;
            rd_dat[ADDR_WIDTH-1:0] = sh_addr[i];
          end
          if (cfg_adr_i == {4'h2, 4'(i)}) begin
            mapped = 1'b1;
            rd_dat[SUB_REGS_DATA_WIDTH-1:0] = sh_data[i];
          end
        end
      end
    endcase
  end

  // STATUS is read-only; every write is refused while a commit is pending so the shadow set stays frozen
  assign err_cond = ~mapped | (cfg_we_i & ((cfg_adr_i == 8'h01) | pending));
  assign wr_en    = req & cfg_we_i & ~err_cond;
  assign wr_ctrl  = wr_en & (cfg_adr_i == 8'h00);

  // Single-cycle ack/err response with registered read data
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cfg_ack_o <= 1'b0;
      cfg_err_o <= 1'b0;
      cfg_dat_o <= '0;
    end else begin
      cfg_ack_o <= req & ~err_cond;
      cfg_err_o <= req & err_cond;
      cfg_dat_o <= (req & ~err_cond) ? rd_dat : '0;
    end
  end

  // Shadow register writes (low bits of the write data)
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sh_pat_gen      <= 1'b0;
      sh_addr_or_data <= 1'b0;
      sh_pen          <= '0;
      sh_nopg         <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        sh_addr[i] <= '0;
        sh_data[i] <= '0;
      end
    end else if (wr_en) begin
      case (cfg_adr_i)
        8'h00: begin
          sh_pat_gen      <= cfg_dat_i[0];
          sh_addr_or_data <= cfg_dat_i[1];
        end
        8'h02: sh_pen  <= cfg_dat_i[NUM_REGS-1:0];
        8'h03: sh_nopg <= cfg_dat_i[NUM_REGS-1:0];
        default: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (cfg_adr_i == {4'h1, 4'(i)}) sh_addr[i] <= cfg_dat_i[ADDR_WIDTH-1:0];
            if (cfg_adr_i == {4'h2, 4'(i)}) sh_data[i] <= cfg_dat_i[SUB_REGS_DATA_WIDTH-1:0];
          end
        end
      endcase
    end
  end

  // Commit FSM: wait for an idle CPU bus (bounded), then copy every shadow value to the active outputs at once
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state              <= ST_IDLE;
      wait_cnt           <= '0;
      timeout_flag       <= 1'b0;
      commit_done_o      <= 1'b0;
      cfg_pat_gen_o      <= 1'b0;
      cfg_addr_or_data_o <= 1'b0;
      ctl_pat_pen_o      <= '0;
      ctl_pat_nopg_o     <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        ctl_pat_addr_o[i] <= '0;
        ctl_pat_data_o[i] <= '0;
      end
    end else begin
      commit_done_o <= 1'b0;
      if (wr_ctrl && cfg_dat_i[9]) timeout_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_ctrl && cfg_dat_i[8]) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (!mon_cyc_i) begin
            state <= ST_APPLY;
          end else if (wait_cnt == TMO_LAST) begin
            state        <= ST_IDLE;
            timeout_flag <= 1'b1;
            wait_cnt     <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_APPLY: begin
          cfg_pat_gen_o      <= sh_pat_gen;
          cfg_addr_or_data_o <= sh_addr_or_data;
          ctl_pat_pen_o      <= sh_pen;
          ctl_pat_nopg_o     <= sh_nopg;
          for (int i = 0; i < NUM_REGS; i++) begin
            ctl_pat_addr_o[i] <= sh_addr[i];
            ctl_pat_data_o[i] <= sh_data[i];
          end
          commit_done_o <= 1'b1;
          state         <= ST_IDLE;
          wait_cnt      <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_patch_cfg_ctrl.sv
// Bench for code_patch_cfg_ctrl: directed scenarios followed by randomized register traffic and commits
// compared against a transaction-level model of the shadow/active register sets.
module tb_code_patch_cfg_ctrl;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int NR  = 3;
  localparam int SDW = 16;
  localparam int TMO = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  cfg_dat_i;
  logic [7:0]     cfg_adr_i;
  logic           cfg_cyc_i, cfg_stb_i, cfg_we_i;
  logic [DW-1:0]  cfg_dat_o;
  logic           cfg_ack_o, cfg_err_o;
  logic           mon_cyc_i;
  logic           cfg_pat_gen_o, cfg_addr_or_data_o;
  logic [AW-1:0]  ctl_pat_addr_o [NR];
  logic [SDW-1:0] ctl_pat_data_o [NR];
  logic [NR-1:0]  ctl_pat_pen_o, ctl_pat_nopg_o;
  logic           commit_done_o;

  int checks = 0;
  int errors = 0;

  // Reference model: shadow (m_*) and active (a_*) register sets
  logic           m_pg, m_aod, m_tmo;
  logic [NR-1:0]  m_pen, m_nopg;
  logic [AW-1:0]  m_addr [NR];
  logic [SDW-1:0] m_data [NR];
  logic           a_pg, a_aod;
  logic [NR-1:0]  a_pen, a_nopg;
  logic [AW-1:0]  a_addr [NR];
  logic [SDW-1:0] a_data [NR];

  code_patch_cfg_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .SUB_REGS_DATA_WIDTH(SDW), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_dat_i(cfg_dat_i), .cfg_adr_i(cfg_adr_i), .cfg_cyc_i(cfg_cyc_i),
    .cfg_stb_i(cfg_stb_i), .cfg_we_i(cfg_we_i), .cfg_dat_o(cfg_dat_o),
    .cfg_ack_o(cfg_ack_o), .cfg_err_o(cfg_err_o), .mon_cyc_i(mon_cyc_i),
    .cfg_pat_gen_o(cfg_pat_gen_o), .cfg_addr_or_data_o(cfg_addr_or_data_o),
    .ctl_pat_addr_o(ctl_pat_addr_o), .ctl_pat_data_o(ctl_pat_data_o),
    .ctl_pat_pen_o(ctl_pat_pen_o), .ctl_pat_nopg_o(ctl_pat_nopg_o),
    .commit_done_o(commit_done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dut_vec();
    return 128'({cfg_pat_gen_o, cfg_addr_or_data_o, ctl_pat_pen_o, ctl_pat_nopg_o,
                 ctl_pat_addr_o[0], ctl_pat_addr_o[1], ctl_pat_addr_o[2],
                 ctl_pat_data_o[0], ctl_pat_data_o[1], ctl_pat_data_o[2]});
  endfunction

  function automatic logic [127:0] model_vec();
    return 128'({a_pg, a_aod, a_pen, a_nopg, a_addr[0], a_addr[1], a_addr[2],
                 a_data[0], a_data[1], a_data[2]});
  endfunction

  task automatic model_reset();
    m_pg = 0; m_aod = 0; m_tmo = 0; m_pen = '0; m_nopg = '0;
    a_pg = 0; a_aod = 0; a_pen = '0; a_nopg = '0;
    for (int i = 0; i < NR; i++) begin
      m_addr[i] = '0; m_data[i] = '0; a_addr[i] = '0; a_data[i] = '0;
    end
  endtask

  task automatic model_apply();
    a_pg = m_pg; a_aod = m_aod; a_pen = m_pen; a_nopg = m_nopg;
    for (int i = 0; i < NR; i++) begin
      a_addr[i] = m_addr[i]; a_data[i] = m_data[i];
    end
  endtask

  // Expected read value of an address while no commit is pending; returns 0 if unmapped
  function automatic bit lookup(input logic [7:0] adr, output logic [15:0] v);
    int a = int'(adr);
    v = '0;
    if (a == 0) begin v = {14'b0, m_aod, m_pg}; return 1; end
    if (a == 1) begin v = {14'b0, m_tmo, 1'b0}; return 1; end
    if (a == 2) begin v = 16'(m_pen); return 1; end
    if (a == 3) begin v = 16'(m_nopg); return 1; end
    if (a >= 16 && a < 16 + NR) begin v = 16'(m_addr[a-16]); return 1; end
    if (a >= 32 && a < 32 + NR) begin v = 16'(m_data[a-32]); return 1; end
    return 0;
  endfunction

  task automatic model_write(input logic [7:0] adr, input logic [15:0] d);
    int a = int'(adr);
    if (a == 0) begin m_pg = d[0]; m_aod = d[1]; if (d[9]) m_tmo = 0; end
    else if (a == 2) m_pen = d[NR-1:0];
    else if (a == 3) m_nopg = d[NR-1:0];
    else if (a >= 16 && a < 16 + NR) m_addr[a-16] = d[AW-1:0];
    else if (a >= 32 && a < 32 + NR) m_data[a-32] = d[SDW-1:0];
  endtask

  // One access, entered and left at a negedge; results sampled the cycle after the request edge
  task automatic bus(input logic we, input logic [7:0] adr, input logic [15:0] d,
                     output logic ak, output logic er, output logic [15:0] rd);
    cfg_cyc_i = 1; cfg_stb_i = 1; cfg_we_i = we; cfg_adr_i = adr; cfg_dat_i = d;
    @(posedge clk); @(negedge clk);
    ak = cfg_ack_o; er = cfg_err_o; rd = cfg_dat_o;
    cfg_cyc_i = 0; cfg_stb_i = 0; cfg_we_i = 0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic rd_chk(input logic [7:0] adr);
    logic ak, er; logic [15:0] rd, v; bit mp;
    bus(0, adr, 16'h0, ak, er, rd);
    mp = lookup(adr, v);
    if (mp) begin
      chk($sformatf("rd_ack[%0h]", adr), 128'(ak), 128'(1));
      chk($sformatf("rd_dat[%0h]", adr), 128'(rd), 128'(v));
    end else begin
      chk($sformatf("rd_err[%0h]", adr), 128'({ak, er}), 128'(2'b01));
    end
  endtask

  task automatic wr_chk(input logic [7:0] adr, input logic [15:0] d);
    logic ak, er; logic [15:0] rd, v; bit mp;
    bus(1, adr, d, ak, er, rd);
    mp = lookup(adr, v);
    if (mp && adr != 8'h01) begin
      chk($sformatf("wr_ack[%0h]", adr), 128'({ak, er}), 128'(2'b10));
      model_write(adr, d);
    end else begin
      chk($sformatf("wr_err[%0h]", adr), 128'({ak, er}), 128'(2'b01));
    end
  endtask

  // Commit with the CPU bus busy for b sampled cycles before going idle
  task automatic commit(input int b, input logic [1:0] bits, input logic clr);
    logic ak, er; logic [15:0] rd, d;
    int nb;
    d = {6'b0, clr, 1'b1, 6'b0, bits};
    mon_cyc_i = (b > 0);
    bus(1, 8'h00, d, ak, er, rd);
    chk("commit_ack", 128'({ak, er}), 128'(2'b10));
    model_write(8'h00, d);
    if (b == 0) begin
      chk("commit_early", dut_vec(), model_vec());
      @(posedge clk); @(negedge clk);
      model_apply();
      chk("commit_active", dut_vec(), model_vec());
      chk("commit_done", 128'(commit_done_o), 128'(1));
    end else begin
      nb = (b >= TMO) ? TMO : b;
      for (int i = 1; i < nb; i++) begin
        @(posedge clk); @(negedge clk);
        chk("busy_hold", dut_vec(), model_vec());
        chk("busy_nodone", 128'(commit_done_o), 128'(0));
      end
      mon_cyc_i = 0;
      if (b >= TMO) begin
        m_tmo = 1;
        chk("tmo_active", dut_vec(), model_vec());
        rd_chk(8'h01);
        chk("tmo_active2", dut_vec(), model_vec());
        chk("tmo_nodone", 128'(commit_done_o), 128'(0));
      end else begin
        @(posedge clk); @(negedge clk);
        chk("idle_hold", dut_vec(), model_vec());
        @(posedge clk); @(negedge clk);
        model_apply();
        chk("busy_active", dut_vec(), model_vec());
        chk("busy_done", 128'(commit_done_o), 128'(1));
      end
    end
    @(posedge clk); @(negedge clk);
    chk("done_pulse", 128'(commit_done_o), 128'(0));
  endtask

  initial begin
    logic ak, er; logic [15:0] rd;
    int acks, consec;
    logic prev;

    rst = 0; cfg_dat_i = '0; cfg_adr_i = '0; cfg_cyc_i = 0; cfg_stb_i = 0;
    cfg_we_i = 0; mon_cyc_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", 128'({cfg_ack_o, cfg_err_o, cfg_dat_o, commit_done_o}), 128'(0));
    chk("rst_active", dut_vec(), 128'(0));
    rst = 1;

    // Every mapped address reads zero; unmapped ones error
    foreach (m_addr[i]) begin rd_chk(8'(16 + i)); rd_chk(8'(32 + i)); end
    for (int a = 0; a < 4; a++) rd_chk(8'(a));
    rd_chk(8'h05); rd_chk(8'(16 + NR)); rd_chk(8'(32 + NR)); rd_chk(8'hFF);

    // Basic commit on an idle bus
    wr_chk(8'h10, 16'h1234); wr_chk(8'h20, 16'hBEEF); wr_chk(8'h02, 16'h0001);
    chk("shadow_only", dut_vec(), 128'(0));
    commit(0, 2'b01, 1'b0);
    chk("pat_addr0", 128'(ctl_pat_addr_o[0]), 128'(16'h1234));
    chk("pat_data0", 128'(ctl_pat_data_o[0]), 128'(16'hBEEF));
    wr_chk(8'h01, 16'hFFFF);

    // Commit held off by a busy bus; pending visible, writes refused
    wr_chk(8'h11, 16'h5A5A); wr_chk(8'h03, 16'h0006);
    mon_cyc_i = 1;
    bus(1, 8'h00, 16'h0102, ak, er, rd);
    chk("wait_ack", 128'({ak, er}), 128'(2'b10));
    model_write(8'h00, 16'h0102);
    for (int i = 0; i < 3; i++) begin
      bus(0, 8'h01, 16'h0, ak, er, rd);
      chk("pending_rd", 128'({ak, rd}), 128'({1'b1, 14'b0, m_tmo, 1'b1}));
    end
    bus(1, 8'h02, 16'h0007, ak, er, rd);
    chk("pending_wr_err", 128'({ak, er}), 128'(2'b01));
    bus(1, 8'h00, 16'h0100, ak, er, rd);
    chk("pending_commit_err", 128'({ak, er}), 128'(2'b01));
    chk("pending_hold", dut_vec(), model_vec());
    mon_cyc_i = 0;
    @(posedge clk); @(negedge clk);
    chk("fall_hold", dut_vec(), model_vec());
    @(posedge clk); @(negedge clk);
    model_apply();
    chk("fall_active", dut_vec(), model_vec());
    chk("fall_done", 128'(commit_done_o), 128'(1));
    @(posedge clk); @(negedge clk);
    rd_chk(8'h02);

    // Timeout, then clear the sticky flag
    wr_chk(8'h21, 16'hCAFE);
    commit(TMO + 2, 2'b11, 1'b0);
    wr_chk(8'h00, 16'h0200);
    rd_chk(8'h01);

    // Reset during WAIT abandons the commit
    wr_chk(8'h12, 16'h7777);
    mon_cyc_i = 1;
    bus(1, 8'h00, 16'h0103, ak, er, rd);
    chk("rstwait_ack", 128'(ak), 128'(1));
    rst = 0;
    @(posedge clk); @(negedge clk);
    rst = 1; mon_cyc_i = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rstwait_nodone", 128'(commit_done_o), 128'(0));
      chk("rstwait_active", dut_vec(), 128'(0));
    end
    for (int a = 0; a < 4; a++) rd_chk(8'(a));
    foreach (m_addr[i]) begin rd_chk(8'(16 + i)); rd_chk(8'(32 + i)); end

    // Strobe held for six cycles
    cfg_cyc_i = 1; cfg_stb_i = 1; cfg_we_i = 0; cfg_adr_i = 8'h02;
    acks = 0; consec = 0; prev = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (cfg_ack_o) begin acks++; if (prev) consec++; end
      prev = cfg_ack_o;
    end
    cfg_cyc_i = 0; cfg_stb_i = 0;
    chk("b2b_acks", 128'(acks), 128'(3));
    chk("b2b_consec", 128'(consec), 128'(0));
    @(posedge clk); @(negedge clk);

    // Cycle dropped before the sampling edge
    cfg_cyc_i = 1; cfg_stb_i = 1; cfg_adr_i = 8'h00;
    #2 cfg_cyc_i = 0;
    @(posedge clk); @(negedge clk);
    chk("cyc_drop", 128'({cfg_ack_o, cfg_err_o}), 128'(0));
    cfg_stb_i = 0;

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      int op;
      logic [7:0] a;
      logic [15:0] d;
      op = int'($urandom_range(0, 9));
      a = 8'($urandom_range(0, 40));
      d = 16'($urandom);
      if (op <= 3) begin
        if (a == 8'h00) d[8] = 1'b0;
        wr_chk(a, d);
      end else if (op <= 6) begin
        rd_chk(a);
      end else if (op <= 8) begin
        commit(int'($urandom_range(0, TMO + 3)), d[1:0], d[9]);
      end else begin
        wr_chk(8'h00, d & 16'hFEFF);
      end
    end
    chk("final_active", dut_vec(), model_vec());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/code_patch_cfg_ctrl.md
Name: code_patch_cfg_ctrl

Overview:
- Wishbone-slave configuration controller for the code-patch datapath. It holds the pattern address/data/enable/no-pattern-generation registers and the two global config bits.
- Software writes shadow copies through a config Wishbone port, then requests a commit.
- The commit FSM waits until the patched CPU bus is idle. It then copies all shadow registers into the active outputs in a single cycle, so the patch logic never sees a half-updated pattern set.

Parameters:
ADDR_WIDTH, 16, width of patched bus address / pattern address registers (must be <= DATA_WIDTH)
DATA_WIDTH, 16, width of config bus data and patched bus data
NUM_REGS, 2, number of pattern entries (1..16)
SUB_REGS_DATA_WIDTH, 16, width of pattern data registers (must be <= DATA_WIDTH)
TIMEOUT, 255, max cycles the commit waits for bus idle (1..65535)

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_i  in  1  synchronous reset, active-low
cfg_dat_i  in  DATA_WIDTH  config write data
cfg_adr_i  in  8  config word address
cfg_cyc_i  in  1  config cycle
cfg_stb_i  in  1  config strobe
cfg_we_i  in  1  config write enable
cfg_dat_o  out  DATA_WIDTH  config read data
cfg_ack_o  out  1  config acknowledge
cfg_err_o  out  1  config error
mon_cyc_i  in  1  cycle signal of the patched CPU bus (bus-busy monitor)
cfg_pat_gen_o  out  1  active pattern-generation enable
cfg_addr_or_data_o  out  1  active address/data mode select
ctl_pat_addr_o  out  ADDR_WIDTH x NUM_REGS  active pattern addresses (unpacked array)
ctl_pat_data_o  out  SUB_REGS_DATA_WIDTH x NUM_REGS  active pattern data (unpacked array)
ctl_pat_pen_o  out  NUM_REGS  active pattern enables
ctl_pat_nopg_o  out  NUM_REGS  active no-pattern-generation flags
commit_done_o  out  1  one-cycle pulse when a commit is applied

Behaviour:
- Reset (rst_i=0 at a clock edge): all shadow and active registers, cfg_ack_o, cfg_err_o, cfg_dat_o, commit_done_o, the FSM state, the timeout counter and the status bits go to 0. Reset mid-commit abandons the commit with no partial apply.
- Register map (word address, shadow unless noted):
  - 0x00 CTRL: bit0 pat_gen, bit1 addr_or_data; bit8 COMMIT (write-1 starts a commit, reads 0).
  - 0x01 STATUS (RO): bit0 pending (FSM not IDLE), bit1 timeout (sticky, cleared by writing 1 to CTRL bit9).
  - 0x02 PEN[NUM_REGS-1:0].
  - 0x03 NOPG[NUM_REGS-1:0].
  - 0x10+i ADDR[i].
  - 0x20+i DATA[i], for i < NUM_REGS.
- Width rules: writes take the low bits of cfg_dat_i. Reads return the shadow value zero-extended to DATA_WIDTH.
- Config handshake:
  - A request is cyc&stb. Exactly one of ack/err pulses for one cycle, in the cycle after the request is sampled.
  - While ack/err is high, the request is not re-sampled (no double ack); min 2 cycles per access.
  - Dropping cyc before the response cancels it.
  - cfg_dat_o is valid with ack.
- Error cases (err instead of ack, no state change):
  - unmapped address;
  - write to STATUS;
  - any shadow write or COMMIT write while pending=1.
- Reads are always allowed.
- FSM:
  - IDLE: on accepted write with bit8=1 -> WAIT. Bits 0/1 of the same write update the shadow first, so the commit includes them.
  - WAIT: counter increments each cycle mon_cyc_i=1.
    - When mon_cyc_i=0 -> APPLY.
    - When counter reaches TIMEOUT with mon_cyc_i still 1 -> IDLE, set timeout, counter cleared, active unchanged.
  - APPLY (1 cycle): all shadow values copied to active outputs simultaneously; commit_done_o=1 in the following cycle; -> IDLE; counter cleared.
- Latency: with bus idle, COMMIT write accepted at edge N -> WAIT at N+1 -> active outputs change at edge N+2 -> commit_done_o high for the cycle after N+2.
- mon_cyc_i rising in the same cycle the FSM samples it low still applies, since the sample was idle.
- Active outputs change only in APPLY or reset.

Test Plan:
- Reset then read every mapped address -> all read 0 with ack; all active outputs 0; read 0x05 -> err=1, ack=0.
- Write ADDR[0]=0x1234, DATA[0]=0xBEEF, PEN=0x1 -> active outputs remain 0; then write CTRL=0x0101 with mon_cyc_i=0 -> 2 edges later ctl_pat_addr_o[0]=0x1234, ctl_pat_data_o[0]=0xBEEF, pen=0x1, pat_gen=1, one commit_done_o pulse.
- Commit with mon_cyc_i=1 for 10 cycles then 0 -> STATUS.pending=1 throughout; write to PEN during wait -> err; outputs update 1 cycle after mon_cyc_i falls.
- TIMEOUT=4, mon_cyc_i held 1 -> after 4 busy cycles pending=0, timeout=1, active unchanged, no commit_done_o; write CTRL bit9 -> timeout=0.
- rst_i=0 asserted during WAIT -> FSM IDLE, all registers 0, no commit_done_o after release.
- Back-to-back stb held high for 6 cycles -> exactly 3 ack pulses, never two consecutive; cyc dropped in request cycle -> no ack.
